// File: rtl/tdm_codec_io_pkg.sv
// Shared constants for the 4-slot TDM codec interface.
// Frame, slot and bit-index field widths derive from these.
package tdm_codec_io_pkg;
    localparam int SLOT_BITS  = 32;
    localparam int N_CH       = 4;
    localparam int FRAME_CLKS = 256;
    localparam int CNT_W      = $clog2(FRAME_CLKS);
    localparam int SLOT_W     = $clog2(N_CH);
    localparam int BIT_W      = $clog2(SLOT_BITS);
endpackage

// File: rtl/tdm_slot_shifter.sv
// W-bit slot shift register: parallel load, MSB-first shift,
// and a capture view of the word as it will be after the shift.
module tdm_slot_shifter #(
    parameter int W = 16
) (
    input  logic         clk_256fs,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic [W-1:0] nxt_o,
    output logic         msb_o
);
    logic [W-1:0] sr_q, sr_d;

    always_comb begin
        nxt_o = {sr_q[W-2:0], ser_i};
        sr_d  = sr_q;
        if (load_i)
            sr_d = load_val_i;
        else if (shift_i)
            sr_d = nxt_o;
    end

    assign msb_o = sr_q[W-1];

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n)
            sr_q <= '0;
        else
            sr_q <= sr_d;
    end
endmodule

// File: rtl/tdm_codec_io.sv
// TDM codec master: 256-clock frame, 4 slots of 32 bick,
// shadowed DAC playback and per-frame ADC capture.
module tdm_codec_io #(
    parameter int W    = 16,
    parameter int N_CH = 4
) (
    input  logic         clk_256fs,
    input  logic         rst_n,
    input  logic [W-1:0] dac0,
    input  logic [W-1:0] dac1,
    input  logic [W-1:0] dac2,
    input  logic [W-1:0] dac3,
    input  logic         sdin,
    output logic         bick,
    output logic         lrck,
    output logic         sdout,
    output logic [W-1:0] adc0,
    output logic [W-1:0] adc1,
    output logic [W-1:0] adc2,
    output logic [W-1:0] adc3,
    output logic         adc_valid,
    output logic         frame_start
);
    import tdm_codec_io_pkg::*;

    localparam int               LASTI = W - 1;
    localparam logic [BIT_W:0]   W_LIM = W[BIT_W:0];
    localparam logic [BIT_W-1:0] LAST  = LASTI[BIT_W-1:0];

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bick_q, lrck_q, sdout_q, sdout_d;
    logic              valid_q, fs_q;
    logic [W-1:0]      dac_w    [N_CH];
    logic [W-1:0]      shadow_q [N_CH];
    logic [W-1:0]      hold_q   [N_CH];
    logic [W-1:0]      adc_q    [N_CH];
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [BIT_W-1:0]  idx_q, idx_d;
    logic              wrap, tx_load, tx_shift, rx_shift, rx_cap;
    logic [W-1:0]      tx_val, tx_nxt, rx_nxt;
    logic              tx_msb, rx_msb;
    logic              unused_bits;

    assign dac_w[0] = dac0;
    assign dac_w[1] = dac1;
    assign dac_w[2] = dac2;
    assign dac_w[3] = dac3;

    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        slot_q   = cnt_q[CNT_W-1 -: SLOT_W];
        slot_d   = cnt_d[CNT_W-1 -: SLOT_W];
        idx_q    = cnt_q[BIT_W:1];
        idx_d    = cnt_d[BIT_W:1];
        wrap     = &cnt_q;
        tx_load  = &cnt_q[BIT_W:0];
        tx_shift = cnt_q[0] & ~tx_load;
        // slot 0 loads on the same edge the shadow captures it
        tx_val   = wrap ? dac_w[0] : shadow_q[slot_d];
        rx_shift = cnt_q[0] & ({1'b0, idx_q} < W_LIM);
        rx_cap   = cnt_q[0] & (idx_q == LAST);
        sdout_d  = sdout_q;
        if (tx_load)
            sdout_d = tx_val[W-1];
        else if (tx_shift)
            sdout_d = ({1'b0, idx_d} < W_LIM) & tx_nxt[W-1];
    end

    tdm_slot_shifter #(.W(W)) u_tx (
        .clk_256fs  (clk_256fs),
        .rst_n      (rst_n),
        .load_i     (tx_load),
        .load_val_i (tx_val),
        .shift_i    (tx_shift),
        .ser_i      (1'b0),
        .nxt_o      (tx_nxt),
        .msb_o      (tx_msb)
    );

    tdm_slot_shifter #(.W(W)) u_rx (
        .clk_256fs  (clk_256fs),
        .rst_n      (rst_n),
        .load_i     (1'b0),
        .load_val_i ('0),
        .shift_i    (rx_shift),
        .ser_i      (sdin),
        .nxt_o      (rx_nxt),
        .msb_o      (rx_msb)
    );

    assign unused_bits = ^{tx_nxt[W-2:0], tx_msb, rx_msb};

    always_ff @(posedge clk_256fs or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bick_q  <= 1'b0;
            lrck_q  <= 1'b1;
            sdout_q <= 1'b0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                shadow_q[k] <= '0;
                hold_q[k]   <= '0;
                adc_q[k]    <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            bick_q  <= cnt_d[0];
            lrck_q  <= ~cnt_d[CNT_W-1];
            sdout_q <= sdout_d;
            valid_q <= wrap;
            fs_q    <= wrap;
            if (rx_cap)
                hold_q[slot_q] <= rx_nxt;
            if (wrap) begin
                for (int k = 0; k < N_CH; k++) begin
                    shadow_q[k] <= dac_w[k];
                    // W==32 finishes slot 3 on the wrap edge itself
                    adc_q[k] <= (rx_cap && slot_q == SLOT_W'(k))
                              ? rx_nxt : hold_q[k];
                end
            end
        end
    end

    assign bick        = bick_q;
    assign lrck        = lrck_q;
    assign sdout       = sdout_q;
    assign adc_valid   = valid_q;
    assign frame_start = fs_q;
    assign adc0        = adc_q[0];
    assign adc1        = adc_q[1];
    assign adc2        = adc_q[2];
    assign adc3        = adc_q[3];
endmodule
